// File: rtl/dot_seq_pkg.sv
// rtl/dot_seq_pkg.sv - shared state encoding and default widths for the dot_seq sequencer
package dot_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        RUN,
        FLUSH,
        SETTLE,
        OUT
    } state_e;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 32;
    localparam int DEF_LEN_W  = 16;
    localparam int DEF_SHIFT  = 0;
    localparam int DEF_OUT_W  = 8;

endpackage

// File: rtl/dot_seq_requant.sv
// rtl/dot_seq_requant.sv - arithmetic shift and signed saturation of the accumulator (used with DOTSEQ_REQUANT_EN)
module dot_seq_requant
    import dot_seq_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int SHIFT = DEF_SHIFT,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic [ACC_W-1:0] acc,
    output logic [ACC_W-1:0] res,
    output logic             sat
);

    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

    logic signed [ACC_W-1:0] shifted;

    assign shifted = $signed(acc) >>> SHIFT;

    // clamp to the signed OUT_W range; the result stays sign-extended to ACC_W
    always_comb begin
        res = shifted;
        sat = 1'b0;
        if (shifted > MAX_V) begin
            res = MAX_V;
            sat = 1'b1;
        end else if (shifted < MIN_V) begin
            res = MIN_V;
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/mac.sv
// rtl/mac.sv - signed multiply-accumulate cell driven by dot_seq (clear has priority over en)
module mac #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc
);

    logic signed [2*DATA_W-1:0] prod;

    assign prod = $signed(a) * $signed(b);

    // accumulation wraps modulo 2^ACC_W; no overflow detection here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
        end
    end

endmodule

// File: rtl/dot_seq.sv
// rtl/dot_seq.sv - operand sequencer and result drain around an external mac; DOTSEQ_REQUANT_EN enables shift+saturate
module dot_seq
    import dot_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int SHIFT  = DEF_SHIFT,
    parameter int OUT_W  = DEF_OUT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_a,
    input  logic [DATA_W-1:0] s_b,
    output logic              mac_clear,
    output logic              mac_en,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    input  logic [ACC_W-1:0]  mac_acc,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ACC_W-1:0]  m_data,
    output logic              m_sat
);

    state_e           state;
    logic [LEN_W-1:0] cnt;
    logic [ACC_W-1:0] result;
    logic             result_sat;
    logic             beat;

    if (OUT_W < 2 || OUT_W > ACC_W || SHIFT < 0 || SHIFT >= ACC_W) begin : g_bad_cfg
        $error("dot_seq: unsupported SHIFT/OUT_W combination");
    end

`ifdef DOTSEQ_REQUANT_EN
    dot_seq_requant #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_requant (
        .acc (mac_acc),
        .res (result),
        .sat (result_sat)
    );
`else
    assign result     = mac_acc;
    assign result_sat = 1'b0;
`endif

    assign beat = s_valid && s_ready;

    // outputs are registered alongside the state so each one is valid in the state it belongs to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            s_ready   <= 1'b0;
            mac_clear <= 1'b0;
            mac_en    <= 1'b0;
            mac_a     <= '0;
            mac_b     <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_sat     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt       <= len;
                        busy      <= 1'b1;
                        mac_clear <= 1'b1;
                        state     <= CLR;
                    end
                end
                CLR: begin
                    mac_clear <= 1'b0;
                    if (cnt != '0) begin
                        s_ready <= 1'b1;
                        state   <= RUN;
                    end else begin
                        state <= SETTLE;
                    end
                end
                RUN: begin
                    if (beat) begin
                        mac_en <= 1'b1;
                        mac_a  <= s_a;
                        mac_b  <= s_b;
                        cnt    <= cnt - LEN_W'(1);
                        if (cnt == LEN_W'(1)) begin
                            s_ready <= 1'b0;
                            state   <= FLUSH;
                        end
                    end else begin
                        mac_en <= 1'b0;
                    end
                end
                FLUSH: begin
                    // mac_en is high during this cycle for the final pair
                    mac_en <= 1'b0;
                    state  <= SETTLE;
                end
                SETTLE: begin
                    m_data  <= result;
                    m_sat   <= result_sat;
                    m_valid <= 1'b1;
                    state   <= OUT;
                end
                OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dot_seq.sv
// tb/tb_dot_seq.sv - scoreboard bench for dot_seq with a mac instance; DOTSEQ_REQUANT_EN selects requant expectations
module tb_dot_seq;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 32;
    localparam int LEN_W  = 16;
    localparam int SHIFT  = 4;
    localparam int OUT_W  = 8;

`ifdef DOTSEQ_REQUANT_EN
    localparam logic [ACC_W-1:0] EXP_70    = 32'd4;
    localparam logic [ACC_W-1:0] EXP_32768 = 32'd127;
    localparam logic [ACC_W-1:0] EXP_M8    = 32'hFFFF_FFFF;
    localparam logic [ACC_W-1:0] EXP_9     = 32'd0;
`else
    localparam logic [ACC_W-1:0] EXP_70    = 32'd70;
    localparam logic [ACC_W-1:0] EXP_32768 = 32'd32768;
    localparam logic [ACC_W-1:0] EXP_M8    = 32'hFFFF_FFF8;
    localparam logic [ACC_W-1:0] EXP_9     = 32'd9;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_a;
    logic [DATA_W-1:0] s_b;
    logic              mac_clear;
    logic              mac_en;
    logic [DATA_W-1:0] mac_a;
    logic [DATA_W-1:0] mac_b;
    logic [ACC_W-1:0]  mac_acc;
    logic              m_valid;
    logic              m_ready;
    logic [ACC_W-1:0]  m_data;
    logic              m_sat;
    logic              mac_rst_n;

    typedef struct {
        logic [ACC_W-1:0] d;
        logic             s;
    } exp_t;

    exp_t             sb[$];
    int               qa[$];
    int               qb[$];
    int               n_chk  = 0;
    int               n_fail = 0;
    int               en_total = 0;
    logic [ACC_W-1:0] last_data;
    logic             last_sat;
    bit               pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    always #5 clk = ~clk;

    assign mac_rst_n = ~rst;

    dot_seq #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .LEN_W  (LEN_W),
        .SHIFT  (SHIFT),
        .OUT_W  (OUT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_a       (s_a),
        .s_b       (s_b),
        .mac_clear (mac_clear),
        .mac_en    (mac_en),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_acc   (mac_acc),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_sat     (m_sat)
    );

    mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (mac_rst_n),
        .clear (mac_clear),
        .en    (mac_en),
        .a     (mac_a),
        .b     (mac_b),
        .acc   (mac_acc)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // reference: plain dot product, wrapped to ACC_W, then optional floor-shift and clamp
    function automatic exp_t model_result();
        longint s = 0;
        exp_t   r;
`ifdef DOTSEQ_REQUANT_EN
        longint v, q, dv, hi, lo;
`endif
        foreach (qa[i]) s += longint'(qa[i]) * longint'(qb[i]);
        r.d = s[ACC_W-1:0];
        r.s = 1'b0;
`ifdef DOTSEQ_REQUANT_EN
        v  = longint'($signed(r.d));
        dv = 64'sd1 <<< SHIFT;
        q  = v / dv;
        if ((v % dv) != 0 && v < 0) q = q - 1;
        hi = (64'sd1 <<< (OUT_W - 1)) - 1;
        lo = -hi - 1;
        if (q > hi) begin
            q = hi;
            r.s = 1'b1;
        end else if (q < lo) begin
            q = lo;
            r.s = 1'b1;
        end
        r.d = q[ACC_W-1:0];
`endif
        return r;
    endfunction

    always @(posedge clk) begin
        if (mac_en) en_total++;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (mac_clear && mac_en) chk("clear_en_overlap", 1, 0);
            if (m_valid && m_ready) begin
                exp_t e;
                last_data = m_data;
                last_sat  = m_sat;
                if (sb.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("m_data", m_data, e.d);
                    chk("m_sat", m_sat, e.s);
                end
            end
        end
    end

    task automatic do_start(input int n);
        sb.push_back(model_result());
        len   = LEN_W'(n);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic feed(input int mode, input int max_beats);
        int i = 0;
        int pi = 0;
        int c = 0;
        while (i < max_beats && c < 400) begin
            if (mode == 0) s_valid = 1'b1;
            else if (mode == 1) s_valid = (pi < 5) ? pat[pi] : 1'b1;
            else s_valid = ($urandom_range(0, 3) != 0);
            s_a = DATA_W'(qa[i]);
            s_b = DATA_W'(qb[i]);
            @(negedge clk);
            if (s_valid && s_ready) i++;
            if (s_ready) pi++;
            @(posedge clk);
            #1;
            c++;
        end
        s_valid = 1'b0;
        chk("beats_accepted", i, max_beats);
    endtask

    // entered just after the last-beat edge (or after start for len=0)
    task automatic finish_dp(input bit measure, input bit rnd);
        int  k = 0;
        bit  seen = 0;
        bit  hs = 0;
        while (!hs && k < 300) begin
            @(negedge clk);
            if (m_valid && !seen) begin
                seen = 1;
                if (measure) chk("result_latency_edges", k, 2);
            end
            hs = m_valid && m_ready;
            @(posedge clk);
            #1;
            k++;
            if (rnd) m_ready = 1'($urandom_range(0, 1));
        end
        m_ready = 1'b1;
        chk("handshake_seen", hs, 1);
        chk("busy_after_handshake", busy, 0);
        chk("m_valid_after_handshake", m_valid, 0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_mac_clear"}, mac_clear, 0);
        chk({tag, "_mac_en"}, mac_en, 0);
        chk({tag, "_mac_a"}, mac_a, 0);
        chk({tag, "_mac_b"}, mac_b, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_m_sat"}, m_sat, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        rst = 1'b1; start = 1'b0; len = '0; s_valid = 1'b0;
        s_a = '0; s_b = '0; m_ready = 1'b1;
        last_data = '0; last_sat = 1'b0;
        #12;
        chk_outputs_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // basic 4-pair product, no stalls
        qa = '{1, 2, 3, 4}; qb = '{5, 6, 7, 8};
        do_start(4); feed(0, 4); finish_dp(1, 0);
        chk("t1_value", last_data, EXP_70);

        // extreme operands and mixed signs
        qa = '{-128, -128}; qb = '{-128, -128};
        do_start(2); feed(0, 2); finish_dp(1, 0);
        chk("t2_value_max", last_data, EXP_32768);
        qa = '{-1, 2, -3}; qb = '{4, 4, 4};
        do_start(3); feed(0, 3); finish_dp(1, 0);
        chk("t2_value_neg", last_data, EXP_M8);

        // s_valid gaps, then output held under backpressure with ignored start pulses
        qa = '{1, 2, 3, 4}; qb = '{5, 6, 7, 8};
        m_ready = 1'b0;
        do_start(4); feed(1, 4);
        for (int w = 0; w < 20 && !m_valid; w++) begin
            @(posedge clk);
            #1;
        end
        for (int w = 0; w < 5; w++) begin
            if (w == 2) begin
                len = LEN_W'(2);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            chk("t3_hold_m_valid", m_valid, 1);
            chk("t3_hold_m_data", m_data, EXP_70);
            chk("t3_hold_busy", busy, 1);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        m_ready = 1'b1;
        finish_dp(0, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("t3_start_ignored_busy", busy, 0);
        chk("t3_start_ignored_s_ready", s_ready, 0);
        chk("t3_sb_empty", sb.size(), 0);

        // empty product
        qa = {}; qb = {};
        n0 = en_total;
        do_start(0); finish_dp(0, 0);
        chk("t4_no_mac_en", en_total - n0, 0);
        chk("t4_value", last_data, 0);

        // asynchronous reset mid-run discards the partial sum
        qa = '{7, 7, 7, 7}; qb = '{9, 9, 9, 9};
        do_start(4); feed(0, 2);
        #2;
        rst = 1'b1;
        #1;
        chk_outputs_zero("midrst");
        chk("midrst_mac_acc", mac_acc, 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        qa = '{3}; qb = '{3};
        do_start(1); feed(0, 1); finish_dp(1, 0);
        chk("t5_value", last_data, EXP_9);

`ifdef DOTSEQ_REQUANT_EN
        qa = '{125}; qb = '{-40};
        do_start(1); feed(0, 1); finish_dp(1, 0);
        chk("t6_value_neg_clamp", last_data, 32'hFFFF_FF80);
        chk("t6_sat_neg_clamp", last_sat, 1);
`endif

        // randomized products with random gaps and random backpressure
        for (int r = 0; r < 30; r++) begin
            int n;
            n = $urandom_range(0, 10);
            qa = {}; qb = {};
            for (int j = 0; j < n; j++) begin
                qa.push_back(($urandom_range(0, 3) == 0) ? -128 : int'($urandom_range(0, 255)) - 128);
                qb.push_back(($urandom_range(0, 3) == 0) ? -128 : int'($urandom_range(0, 255)) - 128);
            end
            m_ready = 1'($urandom_range(0, 1));
            do_start(n);
            if (n > 0) feed(2, n);
            finish_dp(0, 1);
        end

        chk("final_sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
